lcd_frame_writer: RTL

LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

---
 rtl/lcd_frame_writer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_writer.sv
// HD44780-style 4-bit LCD writer: runs the power-up init sequence, then redraws
// a 2x16 character frame from a snapshot of strdata on each refresh request.
module lcd_frame_writer #(
    parameter int T_PWR = 750000,
    parameter int T_EN  = 12,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         refresh,
    input  logic [255:0] strdata,
    output logic         busy,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [3:0]   lcd_d
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(T_PWR, T_EN), max2(T_CMD, T_CLR));
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

    state_t          state, state_n;
    phase_t          phase, phase_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic            nib_hi, nib_hi_n;
    logic [2:0]      step, step_n;
    logic [3:0]      cnt, cnt_n;
    logic            pending, pending_n;
    logic [255:0]    snap;

    logic [7:0]      cur_byte;
    logic            single;
    logic            clr_wait;
    logic [TW-1:0]   wait_last;
    logic            load;
    logic            writing;

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cur_byte = 8'h00;
        unique case (state)
            INIT: begin
                unique case (step)
                    3'd0, 3'd1, 3'd2: cur_byte = 8'h30;
                    3'd3:             cur_byte = 8'h20;
                    3'd4:             cur_byte = 8'h28;
                    3'd5:             cur_byte = 8'h06;
                    3'd6:             cur_byte = 8'h0C;
                    default:          cur_byte = 8'h01;
                endcase
            end
            L1_ADDR: cur_byte = 8'h80;
            L1_CHAR: cur_byte = snap[{1'b1, ~cnt, 3'b000} +: 8];
            L2_ADDR: cur_byte = 8'hC0;
            L2_CHAR: cur_byte = snap[{1'b0, ~cnt, 3'b000} +: 8];
            default: cur_byte = 8'h00;
        endcase
    end

    assign writing   = (state != PWR_WAIT) && (state != IDLE);
    assign busy      = (state != IDLE);
    assign lcd_rw    = 1'b0;
    assign lcd_rs    = (state == L1_CHAR) || (state == L2_CHAR);
    assign lcd_e     = writing && (phase == PH_PULSE);
    assign lcd_d     = nib_hi ? cur_byte[7:4] : cur_byte[3:0];

    // The first four init writes are lone high nibbles; the 0x3 ones and clear need the long wait.
    assign single    = (state == INIT) && (step < 3'd4);
    assign clr_wait  = ((state == INIT) && (step < 3'd3)) || (!lcd_rs && cur_byte == 8'h01);
    assign wait_last = clr_wait ? TW'(T_CLR - 1) : TW'(T_CMD - 1);
    assign load      = (state == IDLE) && (refresh || pending);

    always_comb begin
        logic byte_done;
        state_n   = state;
        phase_n   = phase;
        tmr_n     = tmr;
        nib_hi_n  = nib_hi;
        step_n    = step;
        cnt_n     = cnt;
        pending_n = pending | (refresh && state != IDLE);
        byte_done = 1'b0;

        unique case (state)
            PWR_WAIT: begin
                if (tmr == TW'(T_PWR - 1)) begin
                    state_n  = INIT;
                    tmr_n    = '0;
                    phase_n  = PH_SETUP;
                    nib_hi_n = 1'b1;
                    step_n   = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            IDLE: begin
                if (load) begin
                    state_n   = L1_ADDR;
                    pending_n = 1'b0;
                    tmr_n     = '0;
                    phase_n   = PH_SETUP;
                    nib_hi_n  = 1'b1;
                    cnt_n     = '0;
                end
            end
            default: begin
                unique case (phase)
                    PH_SETUP: begin
                        phase_n = PH_PULSE;
                        tmr_n   = '0;
                    end
                    PH_PULSE: begin
                        if (tmr == TW'(T_EN - 1)) begin
                            phase_n = PH_HOLD;
                            tmr_n   = '0;
                        end else begin
                            tmr_n = tmr + TW'(1);
                        end
                    end
                    PH_HOLD: begin
                        if (tmr == TW'(T_EN - 1)) begin
                            tmr_n = '0;
                            if (nib_hi && !single) begin
                                nib_hi_n = 1'b0;
                                phase_n  = PH_SETUP;
                            end else begin
                                phase_n = PH_WAIT;
                            end
                        end else begin
                            tmr_n = tmr + TW'(1);
                        end
                    end
                    default: begin
                        if (tmr == wait_last) byte_done = 1'b1;
                        else                  tmr_n = tmr + TW'(1);
                    end
                endcase

                if (byte_done) begin
                    tmr_n    = '0;
                    phase_n  = PH_SETUP;
                    nib_hi_n = 1'b1;
                    unique case (state)
                        INIT: begin
                            if (step == 3'd7) state_n = IDLE;
                            else              step_n  = step + 3'd1;
                        end
                        L1_ADDR: state_n = L1_CHAR;
                        L1_CHAR: begin
                            cnt_n = cnt + 4'd1;
                            if (cnt == 4'd15) state_n = L2_ADDR;
                        end
                        L2_ADDR: state_n = L2_CHAR;
                        default: begin
                            cnt_n = cnt + 4'd1;
                            if (cnt == 4'd15) state_n = IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= PWR_WAIT;
            phase   <= PH_SETUP;
            tmr     <= '0;
            nib_hi  <= 1'b1;
            step    <= '0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            tmr     <= tmr_n;
            nib_hi  <= nib_hi_n;
            step    <= step_n;
            cnt     <= cnt_n;
            pending <= pending_n;
        end
    end

    // NOTE: the snapshot is pure data and keeps its contents through reset; only the load is gated.
    always_ff @(posedge clk) begin
        if (rst && load) snap <= strdata;
    end

endmodule
